// File: rtl/axi_mem_slave.sv
// axi_mem_slave
//   AXI4 memory slave emulating an on-chip SRAM/DRAM target. Full-width
//   writes with byte strobes, FIXED/INCR bursts, range-checked SLVERR
//   responses, configurable read latency and independent read/write
//   channels (one outstanding burst per channel).
//
//   Optional feature macro: AXI_MEM_WRAP_EN
//     defined   : WRAP bursts with len in {1,3,7,15} wrap inside an aligned
//                 block of len+1 words; any other WRAP len answers SLVERR.
//     undefined : WRAP is handled like the reserved burst (SLVERR, no write).
//
// Parameters
//   DATA_WIDTH  data bus width (32/64/128)
//   ADDR_WIDTH  AXI byte-address width
//   DEPTH_LOG   memory holds 2^DEPTH_LOG words
//   RD_LAT      wait cycles between AR handshake and first R beat (0..15)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   s_aw{addr,len,burst,valid}  write address in, s_awready out
//   s_w{data,strb,last,valid}   write data in, s_wready out
//   s_bresp, s_bvalid / s_bready write response
//   s_ar{addr,len,burst,valid}  read address in, s_arready out
//   s_r{data,resp,last,valid}   read data out, s_rready in
module axi_mem_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG  = 7,
  parameter int RD_LAT     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = ADDR_WIDTH - OFF;
  localparam int DEPTH = 1 << DEPTH_LOG;

  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [3:0]    WAIT_LAST = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
  localparam logic [1:0]    RESP_OKAY = 2'b00;
  localparam logic [1:0]    RESP_SLV  = 2'b10;
  localparam logic [1:0]    BURST_INCR = 2'b01;
`ifdef AXI_MEM_WRAP_EN
  localparam logic [1:0]    BURST_WRAP = 2'b10;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  // Memory contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Held low through reset so awready/arready rise one edge after release.
  logic r_live;

  // Sub-word address bits are ignored; this sink keeps them visibly consumed.
  logic w_unused;
  assign w_unused = ^{s_awaddr[OFF-1:0], s_araddr[OFF-1:0], s_awlen};

  // Burst types that answer SLVERR on every beat and never write.
  logic w_aw_bad, w_ar_bad;
`ifdef AXI_MEM_WRAP_EN
  function automatic logic f_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           ((burst == 2'b10) &&
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction
  assign w_aw_bad = f_bad(s_awburst, s_awlen);
  assign w_ar_bad = f_bad(s_arburst, s_arlen);
`else
  assign w_aw_bad = s_awburst[1];
  assign w_ar_bad = s_arburst[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // ---------------------------------------------------------------- write
  wstate_t       r_wstate, w_wstate_nxt;
  logic [IW-1:0] r_widx, w_wnext;
  logic [1:0]    r_wburst;
  logic          r_wbad, r_werr;
  logic          w_aw_fire, w_w_fire, w_b_fire, w_w_oob, w_wr_en;

  assign w_aw_fire = s_awready & s_awvalid;
  assign w_w_fire  = s_wready & s_wvalid;
  assign w_b_fire  = s_bvalid & s_bready;
  assign w_w_oob   = |r_widx[IW-1:DEPTH_LOG];
  assign w_wr_en   = w_w_fire & ~r_wbad & ~w_w_oob;
  assign s_bresp   = (r_wstate == W_RESP && r_werr) ? RESP_SLV : RESP_OKAY;

`ifdef AXI_MEM_WRAP_EN
  logic [3:0]    r_wlen;
  logic [IW-1:0] w_wmask;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_wlen <= '0;
    else if (w_aw_fire) r_wlen <= s_awlen[3:0];
  end
  // Wrap: the low len bits count, the rest of the index stays put.
  assign w_wmask = {{(IW-4){1'b0}}, r_wlen};
  assign w_wnext = (r_wburst == BURST_INCR) ? r_widx + IDX_ONE :
                   (r_wburst == BURST_WRAP) ? ((r_widx & ~w_wmask) | ((r_widx + IDX_ONE) & w_wmask)) :
                   r_widx;
`else
  assign w_wnext = (r_wburst == BURST_INCR) ? r_widx + IDX_ONE : r_widx;
`endif

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_awready = r_live;
        if (r_live && s_awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
      r_wburst <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_fire) begin
        r_widx   <= s_awaddr[ADDR_WIDTH-1:OFF];
        r_wburst <= s_awburst;
        r_wbad   <= w_aw_bad;
      end else if (w_w_fire) begin
        r_widx <= w_wnext;
        if (r_wbad || w_w_oob) r_werr <= 1'b1;  // sticky until B handshake
      end
      if (w_b_fire) r_werr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      for (int b = 0; b < BYTES; b++)
        if (s_wstrb[b]) r_mem[r_widx[DEPTH_LOG-1:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
  end

  // ----------------------------------------------------------------- read
  rstate_t         r_rstate, w_rstate_nxt;
  logic [IW-1:0]   r_ridx, w_rnext, w_rload_idx;
  logic [1:0]      r_rburst;
  logic [7:0]      r_rlen, r_rcnt;
  logic [3:0]      r_wait;
  logic            r_rbad, w_rload_bad, w_rload, w_rload_oob;
  logic            w_ar_fire, w_r_fire, w_rlast_beat;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]      r_rresp;

  assign w_ar_fire    = s_arready & s_arvalid;
  assign w_r_fire     = s_rvalid & s_rready;
  assign w_rlast_beat = (r_rcnt == r_rlen);
  assign s_rlast      = (r_rstate == R_DATA) & w_rlast_beat;
  assign s_rdata      = r_rdata;
  assign s_rresp      = r_rresp;

`ifdef AXI_MEM_WRAP_EN
  logic [IW-1:0] w_rmask;
  assign w_rmask = {{(IW-4){1'b0}}, r_rlen[3:0]};
  assign w_rnext = (r_rburst == BURST_INCR) ? r_ridx + IDX_ONE :
                   (r_rburst == BURST_WRAP) ? ((r_ridx & ~w_rmask) | ((r_ridx + IDX_ONE) & w_rmask)) :
                   r_ridx;
`else
  assign w_rnext = (r_rburst == BURST_INCR) ? r_ridx + IDX_ONE : r_ridx;
`endif

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_arready = r_live;
        if (r_live && s_arvalid) w_rstate_nxt = (RD_LAT == 0) ? R_DATA : R_WAIT;
      end
      R_WAIT: if (r_wait == WAIT_LAST) w_rstate_nxt = R_DATA;
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready && w_rlast_beat) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The R data register is loaded on the edge where a beat becomes visible:
  // entering R_DATA, or after a non-final handshake. A write to the same word
  // on that edge is not yet in memory, so the old data is returned.
  always_comb begin
    w_rload     = 1'b0;
    w_rload_idx = r_ridx;
    w_rload_bad = r_rbad;
    if (w_ar_fire && RD_LAT == 0) begin
      w_rload     = 1'b1;
      w_rload_idx = s_araddr[ADDR_WIDTH-1:OFF];
      w_rload_bad = w_ar_bad;
    end else if (r_rstate == R_WAIT && r_wait == WAIT_LAST) begin
      w_rload = 1'b1;
    end else if (w_r_fire && !w_rlast_beat) begin
      w_rload     = 1'b1;
      w_rload_idx = w_rnext;
    end
  end
  assign w_rload_oob = |w_rload_idx[IW-1:DEPTH_LOG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rburst <= '0;
      r_rbad   <= 1'b0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_wait   <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_fire) begin
        r_ridx   <= s_araddr[ADDR_WIDTH-1:OFF];
        r_rburst <= s_arburst;
        r_rbad   <= w_ar_bad;
        r_rlen   <= s_arlen;
        r_rcnt   <= '0;
        r_wait   <= '0;
      end else begin
        if (r_rstate == R_WAIT) r_wait <= r_wait + 4'd1;
        if (w_r_fire && !w_rlast_beat) begin
          r_rcnt <= r_rcnt + 8'd1;
          r_ridx <= w_rnext;
        end
      end
      if (w_rload) begin
        r_rdata <= (w_rload_bad || w_rload_oob) ? '0 : r_mem[w_rload_idx[DEPTH_LOG-1:0]];
        r_rresp <= (w_rload_bad || w_rload_oob) ? RESP_SLV : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave (64-bit data, 128 words, RD_LAT=3).
module tb_axi_mem_slave;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int DL  = 7;
  localparam int LAT = 3;

  logic          clk, rst;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic [1:0]    s_awburst, s_arburst, s_bresp, s_rresp;
  logic          s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic          s_bvalid, s_bready, s_arvalid, s_arready;
  logic          s_rlast, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;

  logic [DW-1:0] wd [16];
  logic [7:0]    ws [16];
  logic [DW-1:0] ed [16];
  logic [1:0]    er [16];

  int n_chk = 0;
  int n_err = 0;

  axi_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG(DL), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Write burst from wd/ws; checks wready timing, bresp and awready return.
  task automatic wr_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] want_resp);
    int t;
    s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 20) begin @(posedge clk); #1; t++; end
    chk({tag, "_awready"}, 64'(s_awready), 64'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    chk({tag, "_wready"}, 64'(s_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == int'(len)); s_wvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(s_bresp), 64'(want_resp));
    @(posedge clk); #1;
    chk({tag, "_bhold"}, 64'({s_bvalid, s_bresp}), 64'({1'b1, want_resp}));
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk({tag, "_awret"}, 64'(s_awready), 64'd1);
  endtask

  // Read burst compared beat by beat against ed/er; optional 2-cycle stall.
  task automatic rd_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat);
    int t;
    int lat;
    s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 20) begin @(posedge clk); #1; t++; end
    chk({tag, "_arready"}, 64'(s_arready), 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_rready = 1'b1;
    lat = 0;
    while (!s_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        s_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s_rready = 1'b1;
      end
      t = 0;
      while (!s_rvalid && t < 20) begin @(posedge clk); #1; t++; end
      chk($sformatf("%s_rvalid%0d", tag, i), 64'(s_rvalid), 64'd1);
      chk($sformatf("%s_rdata%0d", tag, i), s_rdata, ed[i]);
      chk($sformatf("%s_rresp%0d", tag, i), 64'(s_rresp), 64'(er[i]));
      chk($sformatf("%s_rlast%0d", tag, i), 64'(s_rlast), 64'(i == int'(len)));
      @(posedge clk); #1;
    end
    s_rready = 1'b0;
    chk({tag, "_arret"}, 64'(s_arready), 64'd1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'({s_awready, s_arready, s_wready}), 64'd0);
    chk("rst_valid", 64'({s_bvalid, s_rvalid, s_rlast}), 64'd0);
    chk("rst_resp", 64'({s_bresp, s_rresp}), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    rst = 1'b0;
    chk("rel_awready_pre", 64'(s_awready), 64'd0);
    @(posedge clk); #1;
    chk("rel_awready", 64'(s_awready), 64'd1);
    chk("rel_arready", 64'(s_arready), 64'd1);

    // INCR write/read at 0x10 (words 2..5), stall mid-burst
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    wr_burst("incr_wr", 32'h10, 8'd3, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) begin ed[i] = wd[i]; er[i] = 2'b00; end
    rd_burst("incr_rd", 32'h10, 8'd3, 2'b01, 2);

    // Byte strobes at word 32
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    wr_burst("strb_wr1", 32'h100, 8'd0, 2'b01, 2'b00);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    wr_burst("strb_wr2", 32'h100, 8'd0, 2'b01, 2'b00);
    ed[0] = 64'hFFFF_FFFF_0000_0000; er[0] = 2'b00;
    rd_burst("strb_rd", 32'h100, 8'd0, 2'b01, -1);

    // Out of range: word 126, four beats, last two past the end
    wd[0] = 64'hA0A0_A0A0_A0A0_A0A0; wd[1] = 64'hA1A1_A1A1_A1A1_A1A1;
    wd[2] = 64'hA2A2_A2A2_A2A2_A2A2; wd[3] = 64'hA3A3_A3A3_A3A3_A3A3;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    wr_burst("oob_wr", 32'h3F0, 8'd3, 2'b01, 2'b10);
    ed[0] = wd[0]; ed[1] = wd[1]; ed[2] = 64'h0; ed[3] = 64'h0;
    er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
    rd_burst("oob_rd", 32'h3F0, 8'd3, 2'b01, -1);

    // FIXED: both beats land on word 64, last one wins
    wd[0] = 64'h5555_5555_5555_5555; wd[1] = 64'h6666_6666_6666_6666;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    wr_burst("fix_wr", 32'h200, 8'd1, 2'b00, 2'b00);
    ed[0] = wd[1]; ed[1] = wd[1]; er[0] = 2'b00; er[1] = 2'b00;
    rd_burst("fix_rd", 32'h200, 8'd1, 2'b00, -1);

    // Reserved burst: SLVERR, no write to word 2
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    wr_burst("rsv_wr", 32'h10, 8'd0, 2'b11, 2'b10);
    ed[0] = 64'h1111_1111_1111_1111; er[0] = 2'b00;
    rd_burst("rsv_chk", 32'h10, 8'd0, 2'b01, -1);
    ed[0] = 64'h0; er[0] = 2'b10;
    rd_burst("rsv_rd", 32'h10, 8'd0, 2'b11, -1);

    // WRAP read starting at word 6 of block 4..7
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'hC0C0_C0C0_C0C0_C0C4 + 64'(i);
      ws[i] = 8'hFF;
    end
    wr_burst("wrap_fill", 32'h20, 8'd3, 2'b01, 2'b00);
`ifdef AXI_MEM_WRAP_EN
    ed[0] = wd[2]; ed[1] = wd[3]; ed[2] = wd[0]; ed[3] = wd[1];
    for (int i = 0; i < 4; i++) er[i] = 2'b00;
`else
    for (int i = 0; i < 4; i++) begin ed[i] = 64'h0; er[i] = 2'b10; end
`endif
    rd_burst("wrap_rd", 32'h30, 8'd3, 2'b10, -1);

    // Reset in the middle of a read burst
    s_araddr = 32'h10; s_arlen = 8'd3; s_arburst = 2'b01; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    t = 0;
    while (!s_rvalid && t < 40) begin @(posedge clk); #1; t++; end
    chk("mid_rvalid_pre", 64'(s_rvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rvalid", 64'(s_rvalid), 64'd0);
    chk("mid_rdata", s_rdata, 64'd0);
    chk("mid_arready", 64'(s_arready), 64'd0);
    rst = 1'b0;
    chk("mid_arready_pre", 64'(s_arready), 64'd0);
    @(posedge clk); #1;
    chk("mid_arready_rel", 64'(s_arready), 64'd1);
    chk("mid_no_r", 64'(s_rvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Parametrised, synthesizable AXI4 memory slave for on-chip DRAM/SRAM emulation. Serves as the memory target for the QSPI controller's DMA master, replacing byte-only ad-hoc models. Adds:
- full-width writes with byte strobes;
- FIXED/INCR (and optional WRAP) bursts;
- range-checked SLVERR responses;
- configurable read latency;
- independent, concurrent read and write channels.

## Interface
- DATA_WIDTH, 64, data bus width in bits (32/64/128); BYTES = DATA_WIDTH/8
- ADDR_WIDTH, 32, AXI byte-address width
- DEPTH_LOG, 7, memory holds 2^DEPTH_LOG words of DATA_WIDTH
- RD_LAT, 0, extra wait cycles between AR handshake and first R beat (0–15)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_awaddr  in  ADDR_WIDTH  write burst start byte address
- s_awlen  in  8  beats minus one
- s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  BYTES  byte enables
- s_wlast  in  1  final write beat
- s_wvalid  in  1  W valid
- s_wready  out  1  W ready
- s_bresp  out  2  00 OKAY, 10 SLVERR
- s_bvalid  out  1  B valid
- s_bready  in  1  B ready
- s_araddr  in  ADDR_WIDTH  read burst start byte address
- s_arlen  in  8  beats minus one
- s_arburst  in  2  as s_awburst
- s_arvalid  in  1  AR valid
- s_arready  out  1  AR ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  00 OKAY, 10 SLVERR
- s_rlast  out  1  final read beat
- s_rvalid  out  1  R valid
- s_rready  in  1  R ready

## Operation
- **Word index.** Word index = addr >> log2(BYTES). Low address bits are ignored; all beats are full width.
- **Next index by burst type.**
  - FIXED: index held.
  - INCR: index+1.
  - WRAP: index wraps within an aligned block of (len+1) words.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: awready=1. AW handshake latches index, len and burst.
  - W_DATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set, then advances the index. A beat with index ≥ 2^DEPTH_LOG is dropped and sets a sticky error flag. A wlast handshake enters W_RESP. wlast is not length-checked.
  - W_RESP: bvalid=1 with bresp = error flag ? 10 : 00. The B handshake clears the flag and returns to W_IDLE.
- **Read FSM: R_IDLE → R_WAIT → R_DATA → R_IDLE.**
  - R_IDLE: arready=1. AR handshake latches index, len and burst.
  - R_WAIT: counts RD_LAT cycles; skipped when RD_LAT=0.
  - R_DATA: rvalid=1 with registered data for the current index. An out-of-range beat returns rdata=0 and rresp=10. rlast=1 when the beat counter equals len. Each handshake advances; the last-beat handshake returns to R_IDLE.
- **Reserved burst (11).** Every beat responds SLVERR; no memory write.
- **Channel concurrency.** Read and write channels are fully independent. A same-cycle write and read of one word returns the old data; the new data is visible on the next read beat.
- **Memory contents.** Not reset.

## Timing
- **Reset values (rst high).** All FSMs idle. awready=arready=wready=bvalid=rvalid=rlast=0; bresp=rresp=00; rdata=0. awready and arready rise on the first edge after rst falls.
- **Write timing.** AW handshake at edge N gives wready=1 from N+1. W beats are accepted back-to-back. wlast at edge M gives bvalid from M+1, held with bresp stable until bready. awready returns the cycle after the B handshake.
- **Read timing.** AR handshake at edge N gives first rvalid at N+1+RD_LAT. With rready held, beats stream one per cycle. rready low stalls with rdata/rresp/rlast held stable. arready returns the cycle after the last-beat handshake.
- **Outstanding transactions.** One burst at a time per channel; AW/AR are not accepted while busy.
- **Reset mid-burst.** The burst is aborted, outputs go to reset values, and no B or R is issued for it.

## Configuration
- **AXI_MEM_WRAP_EN defined:** WRAP bursts with len ∈ {1,3,7,15} wrap at the (len+1)·BYTES boundary. WRAP with any other len responds SLVERR on all beats, with no write.
- **Undefined:** burst 10 is treated like reserved (SLVERR, no write) and the wrap logic is removed.

## Test plan
- **Reset.** Assert rst mid-read-burst → rvalid=0 next edge. After release, arready=1 one edge later.
- **INCR write/read.** INCR write at 0x10, len=3, data 0x11..11, 0x22..22, 0x33..33, 0x44..44, wstrb=FF → bresp=00. INCR read at 0x10, len=3 returns the same four words, rlast on the 4th, rresp=00.
- **Strobes.** Write 0xFFFF_FFFF_FFFF_FFFF then 0x0 with wstrb=0x0F → read returns 0xFFFF_FFFF_0000_0000.
- **Out of range.** DEPTH_LOG=7, INCR write at word 126, len=3 → words 126–127 written, bresp=10. Read at the same address → beats 3–4 rdata=0, rresp=10.
- **Latency and backpressure.** RD_LAT=3: AR at edge N → first rvalid at N+4. Drop rready for 2 cycles mid-burst → data held, no beat lost.
- **WRAP (AXI_MEM_WRAP_EN).** Read at word 6, len=3 → word order 6, 7, 4, 5. Without the macro → 4 beats of rresp=10.
